// File: rtl/paddle_pkg.sv
// Shared types and helpers for the paddle position controller.
// Pure declarations: no latency and no backpressure of its own.
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  // Timer must hold the larger of the two reload values.
  function automatic int timerWidth(input int delayCycles, input int repeatCycles);
    int largest;
    largest = (delayCycles > repeatCycles) ? delayCycles : repeatCycles;
    return (largest < 1) ? 1 : $clog2(largest + 1);
  endfunction

endpackage

// File: rtl/paddle_if.sv
// Button levels in, registered position and status out.
// Plain levels with no handshake; the controller never stalls its source.
interface paddle_if #(
  parameter int POS_WIDTH = 8
);

  logic                 upButton;
  logic                 downButton;
  logic [POS_WIDTH-1:0] position;
  logic                 stepPulse;
  logic                 atMax;
  logic                 atMin;

  modport master (
    output upButton,
    output downButton,
    input  position,
    input  stepPulse,
    input  atMax,
    input  atMin
  );

  modport slave (
    input  upButton,
    input  downButton,
    output position,
    output stepPulse,
    output atMax,
    output atMin
  );

endinterface

// File: rtl/paddle_position_ctrl_sync2.sv
// Two-flop synchroniser for one asynchronous level.
// Two clock cycles of latency; no backpressure.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_position_ctrl.sv
// Turns held up/down keys into saturating position steps with press-then-auto-repeat timing.
// Step lands two edges after a key is first sampled; no backpressure, outputs are registered.
module paddle_position_ctrl
  import paddle_pkg::*;
#(
  parameter int POS_WIDTH     = 8,
  parameter int POS_MIN       = 0,
  parameter int POS_MAX       = 255,
  parameter int POS_INIT      = 128,
  parameter int STEP          = 1,
  parameter int DELAY_CYCLES  = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic     clock,
  input  logic     reset,
  paddle_if.slave  bus
);

  localparam int TW = timerWidth(DELAY_CYCLES, REPEAT_CYCLES);
  localparam int EW = POS_WIDTH + 1;

  localparam logic [TW-1:0]        DELAY_LOAD  = TW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0]        REPEAT_LOAD = TW'(REPEAT_CYCLES - 1);
  localparam logic [POS_WIDTH-1:0] P_MIN       = POS_WIDTH'(POS_MIN);
  localparam logic [POS_WIDTH-1:0] P_MAX       = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0] P_INIT      = POS_WIDTH'(POS_INIT);
  localparam logic [EW-1:0]        E_MAX       = EW'(POS_MAX);
  localparam logic [EW-1:0]        E_STEP      = EW'(STEP);
  localparam logic [EW-1:0]        E_LOW_EDGE  = EW'(POS_MIN + STEP);

  logic upS;
  logic downS;

  sync2 uSyncUp (
    .clock (clock),
    .reset (reset),
    .d     (bus.upButton),
    .q     (upS)
  );

  sync2 uSyncDown (
    .clock (clock),
    .reset (reset),
    .d     (bus.downButton),
    .q     (downS)
  );

  rep_state_t           state;
  rep_state_t           stateNext;
  dir_t                 dir;
  dir_t                 dirNext;
  dir_t                 req;
  dir_t                 stepDir;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        timerNext;
  logic                 doStep;
  logic [POS_WIDTH-1:0] position;
  logic                 stepPulse;
  logic [EW-1:0]        posExt;
  logic [EW-1:0]        upSum;
  logic [POS_WIDTH-1:0] stepTarget;

  // Both keys held cancel each other out.
  always_comb begin
    req = DIR_NONE;
    if (upS && !downS) begin
      req = DIR_UP;
    end else if (downS && !upS) begin
      req = DIR_DOWN;
    end
  end

  always_comb begin
    stateNext = state;
    dirNext   = dir;
    timerNext = timer;
    doStep    = 1'b0;
    stepDir   = dir;
    case (state)
      IDLE: begin
        if (req != DIR_NONE) begin
          doStep    = 1'b1;
          stepDir   = req;
          dirNext   = req;
          timerNext = DELAY_LOAD;
          stateNext = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (req == DIR_NONE) begin
          timerNext = '0;
          stateNext = IDLE;
        end else if (req != dir) begin
          // A direction reversal restarts the hold sequence from a fresh press.
          doStep    = 1'b1;
          stepDir   = req;
          dirNext   = req;
          timerNext = DELAY_LOAD;
          stateNext = DELAY;
        end else if (timer != '0) begin
          timerNext = timer - TW'(1);
        end else begin
          doStep    = 1'b1;
          timerNext = REPEAT_LOAD;
          stateNext = REPEAT;
        end
      end
      default: begin
        timerNext = '0;
        dirNext   = DIR_NONE;
        stateNext = IDLE;
      end
    endcase
  end

  // One extra bit keeps the upward sum from wrapping before the clamp.
  always_comb begin
    posExt     = {1'b0, position};
    upSum      = posExt + E_STEP;
    stepTarget = position;
    if (stepDir == DIR_UP) begin
      stepTarget = (upSum > E_MAX) ? P_MAX : POS_WIDTH'(upSum);
    end else if (stepDir == DIR_DOWN) begin
      stepTarget = (posExt < E_LOW_EDGE) ? P_MIN : POS_WIDTH'(posExt - E_STEP);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dir   <= DIR_NONE;
      timer <= '0;
    end else begin
      state <= stateNext;
      dir   <= dirNext;
      timer <= timerNext;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      position  <= P_INIT;
      stepPulse <= 1'b0;
    end else begin
      stepPulse <= doStep && (stepTarget != position);
      if (doStep) begin
        position <= stepTarget;
      end
    end
  end

  assign bus.position  = position;
  assign bus.stepPulse = stepPulse;
  assign bus.atMax     = (position == P_MAX);
  assign bus.atMin     = (position == P_MIN);

endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Directed scenarios for paddle_position_ctrl, checked every cycle against an age-based model
// and at hand-computed points against literal expectations.
module tb_paddle_position_ctrl;

  localparam int PW   = 4;
  localparam int PMIN = 2;
  localparam int PMAX = 12;
  localparam int PINI = 7;
  localparam int PSTP = 2;
  localparam int DLY  = 5;
  localparam int RPT  = 3;

  logic clock;
  logic reset;
  logic clkEn;
  logic probe;

  paddle_if #(.POS_WIDTH(PW)) bus ();

  paddle_position_ctrl #(
    .POS_WIDTH     (PW),
    .POS_MIN       (PMIN),
    .POS_MAX       (PMAX),
    .POS_INIT      (PINI),
    .STEP          (PSTP),
    .DELAY_CYCLES  (DLY),
    .REPEAT_CYCLES (RPT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever begin
      #5;
      if (clkEn) clock = ~clock;
    end
  end

  // Model: a key level seen at edge n acts at edge n+2; a step happens on a fresh
  // request, then when the hold age reaches DLY, then every RPT edges after that.
  int u1, u2, d1, d2;
  int mPos, mPulse, prevReq, age;
  int req, np;
  bit step;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      u1 = 0; u2 = 0; d1 = 0; d2 = 0;
      mPos = PINI; mPulse = 0; prevReq = 0; age = 0;
    end else begin
      req = (u2 == 1 && d2 == 0) ? 1 : (d2 == 1 && u2 == 0) ? 2 : 0;
      step = 1'b0;
      if (req != 0) begin
        if (req != prevReq) begin
          step = 1'b1;
          age = 0;
        end else begin
          age = age + 1;
          if (age == DLY || (age > DLY && (age - DLY) % RPT == 0)) step = 1'b1;
        end
      end
      prevReq = req;
      mPulse = 0;
      if (step) begin
        if (req == 1) np = (mPos + PSTP > PMAX) ? PMAX : mPos + PSTP;
        else          np = (mPos - PSTP < PMIN) ? PMIN : mPos - PSTP;
        mPulse = (np != mPos) ? 1 : 0;
        mPos = np;
      end
      u2 = u1; u1 = int'(bus.upButton);
      d2 = d1; d1 = int'(bus.downButton);
    end
  end

  int nCmp = 0;
  int nBad = 0;
  int cyc = 0;
  int tcyc = 0;

  logic       pinVld  [0:511];
  logic [6:0] pinExp  [0:511];
  string      pinName [0:511];

  logic [6:0] got;
  logic [6:0] exp;

  task automatic check(input string nm, input logic [6:0] g, input logic [6:0] e);
    nCmp++;
    if (g !== e) begin
      nBad++;
      $display("FAIL %s cycle %0d: got pos=%0d pulse=%0b max=%0b min=%0b, want pos=%0d pulse=%0b max=%0b min=%0b",
               nm, cyc, g[6:3], g[2], g[1], g[0], e[6:3], e[2], e[1], e[0]);
    end
  endtask

  always @(negedge clock or posedge probe) begin
    got = {bus.position, bus.stepPulse, bus.atMax, bus.atMin};
    if (probe) begin
      check("reset_noclock", got, {4'(PINI), 1'b0, 1'b0, 1'b0});
    end else begin
      cyc++;
      exp = {4'(mPos), 1'(mPulse), (mPos == PMAX), (mPos == PMIN)};
      check("model", got, exp);
      if (pinVld[cyc] === 1'b1) check(pinName[cyc], got, pinExp[cyc]);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clock);
      tcyc++;
    end
  endtask

  task automatic pin(input int m, input int pos, input bit pulse, input string nm);
    pinVld[tcyc+m]  = 1'b1;
    pinExp[tcyc+m]  = {4'(pos), pulse, (pos == PMAX), (pos == PMIN)};
    pinName[tcyc+m] = nm;
  endtask

  task automatic doReset();
    bus.upButton   = 1'b0;
    bus.downButton = 1'b0;
    cycles(1);
    #2 reset = 1'b1;
    cycles(2);
    #2 reset = 1'b0;
    cycles(3);
  endtask

  initial begin
    clkEn = 1'b0;
    probe = 1'b0;
    reset = 1'b0;
    bus.upButton   = 1'b0;
    bus.downButton = 1'b0;
    #1 reset = 1'b1;
    #2 probe = 1'b1;
    #1 probe = 1'b0;
    clkEn = 1'b1;
    cycles(2);
    #2 reset = 1'b0;
    cycles(3);

    // Single-cycle tap on up.
    pin(2, 7, 1'b0, "tap_before");
    pin(3, 9, 1'b1, "tap_step");
    pin(4, 9, 1'b0, "tap_pulse_end");
    pin(10, 9, 1'b0, "tap_no_repeat");
    bus.upButton = 1'b1;
    cycles(1);
    bus.upButton = 1'b0;
    cycles(11);

    // Held up into the upper bound.
    doReset();
    pin(3, 9, 1'b1, "up_initial");
    pin(4, 9, 1'b0, "up_hold");
    pin(8, 11, 1'b1, "up_first_repeat");
    pin(11, 12, 1'b1, "up_saturate");
    pin(14, 12, 1'b0, "up_repeat_at_max");
    bus.upButton = 1'b1;
    cycles(15);
    bus.upButton = 1'b0;
    cycles(4);

    // Both keys together never step.
    doReset();
    pin(3, 7, 1'b0, "both_early");
    pin(8, 7, 1'b0, "both_delay");
    pin(12, 7, 1'b0, "both_late");
    bus.upButton   = 1'b1;
    bus.downButton = 1'b1;
    cycles(13);
    bus.upButton   = 1'b0;
    bus.downButton = 1'b0;
    cycles(3);

    // Down then reverse to up mid-delay.
    doReset();
    pin(3, 5, 1'b1, "rev_down");
    pin(6, 5, 1'b0, "rev_wait");
    pin(7, 7, 1'b1, "rev_up");
    pin(11, 7, 1'b0, "rev_up_delay");
    pin(12, 9, 1'b1, "rev_up_repeat");
    bus.downButton = 1'b1;
    cycles(4);
    bus.downButton = 1'b0;
    bus.upButton   = 1'b1;
    cycles(10);
    bus.upButton = 1'b0;
    cycles(3);

    // Held down into the lower bound.
    doReset();
    pin(3, 5, 1'b1, "dn_initial");
    pin(8, 3, 1'b1, "dn_first_repeat");
    pin(11, 2, 1'b1, "dn_saturate");
    pin(14, 2, 1'b0, "dn_repeat_at_min");
    bus.downButton = 1'b1;
    cycles(15);
    bus.downButton = 1'b0;
    cycles(3);

    // Reset mid-hold, key still held on release.
    doReset();
    pin(3, 5, 1'b1, "rst_hold_step");
    bus.downButton = 1'b1;
    cycles(4);
    #2 reset = 1'b1;
    pin(1, 7, 1'b0, "rst_in_reset");
    cycles(2);
    #2 reset = 1'b0;
    pin(2, 7, 1'b0, "rst_released");
    pin(3, 5, 1'b1, "rst_fresh_press");
    cycles(6);
    bus.downButton = 1'b0;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
